// File: rtl/reg_write_arbiter.sv
// Single register-file write port: pipeline writeback (fixed priority) merged with a FIFO-buffered long-latency source.
// Latency: pipe 1 cycle; long-latency >= 2 cycles (1 with REG_WRITE_ARB_BYPASS_EN defined, FIFO empty, pipe idle).
// Backpressure: lu_ready = !full (0 in reset); pipeline is never stalled.
module reg_write_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          pipe_wen,
  input  logic [ADDR_WIDTH-1:0]         pipe_waddr,
  input  logic [DATA_WIDTH-1:0]         pipe_wdata,
  input  logic                          lu_valid,
  output logic                          lu_ready,
  input  logic [ADDR_WIDTH-1:0]         lu_waddr,
  input  logic [DATA_WIDTH-1:0]         lu_wdata,
  output logic                          write_en,
  output logic [ADDR_WIDTH-1:0]         write_addr,
  output logic [DATA_WIDTH-1:0]         write_data,
  input  logic [ADDR_WIDTH-1:0]         query_addr,
  output logic                          query_hit,
  output logic [$clog2(FIFO_DEPTH):0]   pend_cnt
);
  localparam int PW = $clog2(FIFO_DEPTH);

  logic [PW:0]           wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] mem_data_q [FIFO_DEPTH];
  logic                  write_en_q, write_en_d;
  logic [ADDR_WIDTH-1:0] write_addr_q, write_addr_d;
  logic [DATA_WIDTH-1:0] write_data_q, write_data_d;

  logic empty, full, lu_live, pipe_vld, bypass, push, pop;
  logic [PW-1:0] offs;

  always_comb begin
    empty    = (wr_ptr_q == rd_ptr_q);
    full     = (wr_ptr_q[PW] != rd_ptr_q[PW]) && (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
    lu_ready = rst && !full;
    // Address-0 results complete the handshake but are discarded.
    lu_live  = lu_valid && lu_ready && (lu_waddr != '0);
    pipe_vld = pipe_wen && (pipe_waddr != '0);
`ifdef REG_WRITE_ARB_BYPASS_EN
    bypass   = empty && !pipe_vld && lu_live;
`else
    bypass   = 1'b0;
`endif
    push     = lu_live && !bypass;
    // Pop decision uses registered state only, so a fresh push is never popped the same cycle.
    pop      = !pipe_vld && !empty;
    wr_ptr_d = wr_ptr_q + (PW+1)'(push);
    rd_ptr_d = rd_ptr_q + (PW+1)'(pop);
    pend_cnt = wr_ptr_q - rd_ptr_q;
  end

  always_comb begin
    write_en_d   = 1'b0;
    write_addr_d = write_addr_q;
    write_data_d = write_data_q;
    if (pipe_vld) begin
      write_en_d   = 1'b1;
      write_addr_d = pipe_waddr;
      write_data_d = pipe_wdata;
    end else if (pop) begin
      write_en_d   = 1'b1;
      write_addr_d = mem_addr_q[rd_ptr_q[PW-1:0]];
      write_data_d = mem_data_q[rd_ptr_q[PW-1:0]];
    end else if (bypass) begin
      write_en_d   = 1'b1;
      write_addr_d = lu_waddr;
      write_data_d = lu_wdata;
    end
  end

  // An entry is live when its distance from the read pointer is below the occupancy.
  always_comb begin
    query_hit = 1'b0;
    offs      = '0;
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      offs = PW'(i) - rd_ptr_q[PW-1:0];
      if (({1'b0, offs} < pend_cnt) && (mem_addr_q[i] == query_addr) && (query_addr != '0))
        query_hit = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      write_en_q   <= 1'b0;
      write_addr_q <= '0;
      write_data_q <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_addr_q[i] <= '0;
        mem_data_q[i] <= '0;
      end
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      write_en_q   <= write_en_d;
      write_addr_q <= write_addr_d;
      write_data_q <= write_data_d;
      if (push) begin
        mem_addr_q[wr_ptr_q[PW-1:0]] <= lu_waddr;
        mem_data_q[wr_ptr_q[PW-1:0]] <= lu_wdata;
      end
    end
  end

  assign write_en   = write_en_q;
  assign write_addr = write_addr_q;
  assign write_data = write_data_q;
endmodule

// File: tb/tb_reg_write_arbiter.sv
// Directed bench for reg_write_arbiter: vector table plus hand sequences for reset, latency and mid-run reset.
module tb_reg_write_arbiter;
  logic        clk = 1'b0;
  logic        rst;
  logic        pipe_wen;
  logic [4:0]  pipe_waddr;
  logic [31:0] pipe_wdata;
  logic        lu_valid;
  logic        lu_ready;
  logic [4:0]  lu_waddr;
  logic [31:0] lu_wdata;
  logic        write_en;
  logic [4:0]  write_addr;
  logic [31:0] write_data;
  logic [4:0]  query_addr;
  logic        query_hit;
  logic [2:0]  pend_cnt;

  int checks = 0;
  int errors = 0;

  reg_write_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .pipe_wen(pipe_wen), .pipe_waddr(pipe_waddr), .pipe_wdata(pipe_wdata),
    .lu_valid(lu_valid), .lu_ready(lu_ready), .lu_waddr(lu_waddr), .lu_wdata(lu_wdata),
    .write_en(write_en), .write_addr(write_addr), .write_data(write_data),
    .query_addr(query_addr), .query_hit(query_hit), .pend_cnt(pend_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        pw;  logic [4:0] pa; logic [31:0] pd;
    logic        lv;  logic [4:0] la; logic [31:0] ld;
    logic [4:0]  qa;
    logic        e_rdy; logic e_hit; logic [2:0] e_cnt;
    logic        e_en;  logic [4:0] e_addr; logic [31:0] e_data;
  } vec_t;

  vec_t vq[$];

  task automatic v(input logic pw, input logic [4:0] pa, input logic [31:0] pd,
                   input logic lv, input logic [4:0] la, input logic [31:0] ld,
                   input logic [4:0] qa, input logic e_rdy, input logic e_hit,
                   input logic [2:0] e_cnt, input logic e_en, input logic [4:0] e_addr,
                   input logic [31:0] e_data);
    vec_t t;
    t.pw = pw; t.pa = pa; t.pd = pd; t.lv = lv; t.la = la; t.ld = ld; t.qa = qa;
    t.e_rdy = e_rdy; t.e_hit = e_hit; t.e_cnt = e_cnt;
    t.e_en = e_en; t.e_addr = e_addr; t.e_data = e_data;
    vq.push_back(t);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", nm, act, exp);
    end
  endtask

  task automatic idle();
    pipe_wen = 1'b0; pipe_waddr = 5'd0; pipe_wdata = 32'h0;
    lu_valid = 1'b0; lu_waddr = 5'd0; lu_wdata = 32'h0; query_addr = 5'd0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // pipe write + hold
    v(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'h0, 5'd0, 1'b1, 1'b0, 3'd0, 1'b1, 5'd5, 32'hDEADBEEF);
    v(1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0, 5'd0, 1'b1, 1'b0, 3'd0, 1'b0, 5'd5, 32'hDEADBEEF);
    // address-0 writes from either source are dropped
    v(1'b1, 5'd0, 32'h1234,     1'b0, 5'd0, 32'h0, 5'd0, 1'b1, 1'b0, 3'd0, 1'b0, 5'd5, 32'hDEADBEEF);
    v(1'b0, 5'd0, 32'h0,        1'b1, 5'd0, 32'h55, 5'd0, 1'b1, 1'b0, 3'd0, 1'b0, 5'd5, 32'hDEADBEEF);
    v(1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0, 5'd0, 1'b1, 1'b0, 3'd0, 1'b0, 5'd5, 32'hDEADBEEF);
    // pipe busy 1..6 while LU pushes 10..14, then drain in order
    v(1'b1, 5'd1, 32'h101, 1'b1, 5'd10, 32'h20A, 5'd0,  1'b1, 1'b0, 3'd0, 1'b1, 5'd1, 32'h101);
    v(1'b1, 5'd2, 32'h102, 1'b1, 5'd11, 32'h20B, 5'd10, 1'b1, 1'b1, 3'd1, 1'b1, 5'd2, 32'h102);
    v(1'b1, 5'd3, 32'h103, 1'b1, 5'd12, 32'h20C, 5'd0,  1'b1, 1'b0, 3'd2, 1'b1, 5'd3, 32'h103);
    v(1'b1, 5'd4, 32'h104, 1'b1, 5'd13, 32'h20D, 5'd0,  1'b1, 1'b0, 3'd3, 1'b1, 5'd4, 32'h104);
    v(1'b1, 5'd5, 32'h105, 1'b1, 5'd14, 32'h20E, 5'd12, 1'b0, 1'b1, 3'd4, 1'b1, 5'd5, 32'h105);
    v(1'b1, 5'd6, 32'h106, 1'b1, 5'd14, 32'h20E, 5'd14, 1'b0, 1'b0, 3'd4, 1'b1, 5'd6, 32'h106);
    v(1'b0, 5'd0, 32'h0,   1'b1, 5'd14, 32'h20E, 5'd0,  1'b0, 1'b0, 3'd4, 1'b1, 5'd10, 32'h20A);
    v(1'b0, 5'd0, 32'h0,   1'b1, 5'd14, 32'h20E, 5'd0,  1'b1, 1'b0, 3'd3, 1'b1, 5'd11, 32'h20B);
    v(1'b0, 5'd0, 32'h0,   1'b0, 5'd0,  32'h0,   5'd11, 1'b1, 1'b0, 3'd3, 1'b1, 5'd12, 32'h20C);
    v(1'b0, 5'd0, 32'h0,   1'b0, 5'd0,  32'h0,   5'd14, 1'b1, 1'b1, 3'd2, 1'b1, 5'd13, 32'h20D);
    v(1'b0, 5'd0, 32'h0,   1'b0, 5'd0,  32'h0,   5'd0,  1'b1, 1'b0, 3'd1, 1'b1, 5'd14, 32'h20E);
    v(1'b0, 5'd0, 32'h0,   1'b0, 5'd0,  32'h0,   5'd0,  1'b1, 1'b0, 3'd0, 1'b0, 5'd14, 32'h20E);
    // query_hit lifetime for addr 7, and query 0 never hits
    v(1'b1, 5'd1, 32'h301, 1'b1, 5'd7, 32'h777, 5'd7, 1'b1, 1'b0, 3'd0, 1'b1, 5'd1, 32'h301);
    v(1'b1, 5'd2, 32'h302, 1'b0, 5'd0, 32'h0,   5'd7, 1'b1, 1'b1, 3'd1, 1'b1, 5'd2, 32'h302);
    v(1'b0, 5'd0, 32'h0,   1'b0, 5'd0, 32'h0,   5'd7, 1'b1, 1'b1, 3'd1, 1'b1, 5'd7, 32'h777);
    v(1'b0, 5'd0, 32'h0,   1'b0, 5'd0, 32'h0,   5'd7, 1'b1, 1'b0, 3'd0, 1'b0, 5'd7, 32'h777);
    v(1'b1, 5'd3, 32'h303, 1'b1, 5'd8, 32'h888, 5'd0, 1'b1, 1'b0, 3'd0, 1'b1, 5'd3, 32'h303);
    v(1'b1, 5'd0, 32'h0,   1'b0, 5'd0, 32'h0,   5'd0, 1'b1, 1'b0, 3'd1, 1'b1, 5'd8, 32'h888);
    v(1'b0, 5'd0, 32'h0,   1'b0, 5'd0, 32'h0,   5'd8, 1'b1, 1'b0, 3'd0, 1'b0, 5'd8, 32'h888);

    // Reset held 3 cycles with lu_valid asserted
    idle();
    rst = 1'b0;
    lu_valid = 1'b1; lu_waddr = 5'd3; lu_wdata = 32'hCAFE;
    for (int c = 0; c < 3; c++) begin
      tick();
      chk($sformatf("rst%0d_en", c), 32'(write_en), 32'd0);
      chk($sformatf("rst%0d_addr", c), 32'(write_addr), 32'd0);
      chk($sformatf("rst%0d_data", c), write_data, 32'd0);
      chk($sformatf("rst%0d_rdy", c), 32'(lu_ready), 32'd0);
      chk($sformatf("rst%0d_cnt", c), 32'(pend_cnt), 32'd0);
    end
    rst = 1'b1;
    idle();
    tick();
    chk("rel_rdy", 32'(lu_ready), 32'd1);
    chk("rel_en", 32'(write_en), 32'd0);
    chk("rel_cnt", 32'(pend_cnt), 32'd0);

    for (int k = 0; k < vq.size(); k++) begin
      pipe_wen = vq[k].pw; pipe_waddr = vq[k].pa; pipe_wdata = vq[k].pd;
      lu_valid = vq[k].lv; lu_waddr = vq[k].la; lu_wdata = vq[k].ld;
      query_addr = vq[k].qa;
      #1;
      chk($sformatf("v%0d_rdy", k), 32'(lu_ready), 32'(vq[k].e_rdy));
      chk($sformatf("v%0d_hit", k), 32'(query_hit), 32'(vq[k].e_hit));
      chk($sformatf("v%0d_cnt", k), 32'(pend_cnt), 32'(vq[k].e_cnt));
      tick();
      chk($sformatf("v%0d_en", k), 32'(write_en), 32'(vq[k].e_en));
      chk($sformatf("v%0d_addr", k), 32'(write_addr), 32'(vq[k].e_addr));
      chk($sformatf("v%0d_data", k), write_data, vq[k].e_data);
    end

    // LU latency with FIFO empty and pipe idle
    idle();
    lu_valid = 1'b1; lu_waddr = 5'd9; lu_wdata = 32'hA5A5A5A5;
    #1;
    chk("lat_rdy", 32'(lu_ready), 32'd1);
    tick();
    idle();
`ifdef REG_WRITE_ARB_BYPASS_EN
    chk("lat1_en", 32'(write_en), 32'd1);
    chk("lat1_addr", 32'(write_addr), 32'd9);
    chk("lat1_data", write_data, 32'hA5A5A5A5);
    chk("lat1_cnt", 32'(pend_cnt), 32'd0);
    tick();
    chk("lat2_en", 32'(write_en), 32'd0);
    chk("lat2_cnt", 32'(pend_cnt), 32'd0);
`else
    chk("lat1_en", 32'(write_en), 32'd0);
    chk("lat1_cnt", 32'(pend_cnt), 32'd1);
    tick();
    chk("lat2_en", 32'(write_en), 32'd1);
    chk("lat2_addr", 32'(write_addr), 32'd9);
    chk("lat2_data", write_data, 32'hA5A5A5A5);
    chk("lat2_cnt", 32'(pend_cnt), 32'd0);
`endif

    // Reset mid-operation discards queued entries
    pipe_wen = 1'b1; pipe_waddr = 5'd1; pipe_wdata = 32'h1;
    lu_valid = 1'b1; lu_waddr = 5'd20; lu_wdata = 32'h14;
    tick();
    pipe_waddr = 5'd2; lu_waddr = 5'd21; lu_wdata = 32'h15;
    tick();
    idle();
    query_addr = 5'd20;
    #1;
    chk("mid_cnt", 32'(pend_cnt), 32'd2);
    chk("mid_hit", 32'(query_hit), 32'd1);
    #1;
    rst = 1'b0;
    #1;
    chk("arst_cnt", 32'(pend_cnt), 32'd0);
    chk("arst_hit", 32'(query_hit), 32'd0);
    chk("arst_en", 32'(write_en), 32'd0);
    chk("arst_addr", 32'(write_addr), 32'd0);
    chk("arst_data", write_data, 32'd0);
    chk("arst_rdy", 32'(lu_ready), 32'd0);
    tick();
    rst = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      chk($sformatf("post%0d_en", c), 32'(write_en), 32'd0);
      chk($sformatf("post%0d_cnt", c), 32'(pend_cnt), 32'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/reg_write_arbiter.md
Name: reg_write_arbiter

Overview:
- Owns the single write channel of the 32-entry register file. Merges two writeback sources: the in-order pipeline writeback stage, which has fixed priority and is never stalled, and a long-latency unit (divider/load), which uses a valid/ready handshake and is buffered in a small FIFO.
- Drives registered write_en/write_addr/write_data into the register file.
- Provides a pending-address query so decode can stall on results still queued.

Parameters:
- DATA_WIDTH, 32, width of write data.
- ADDR_WIDTH, 5, register address width.
- FIFO_DEPTH, 4, long-latency entries buffered; power of 2, at least 2.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- pipe_wen  input  1  pipeline writeback request this cycle.
- pipe_waddr  input  ADDR_WIDTH  pipeline destination register.
- pipe_wdata  input  DATA_WIDTH  pipeline result.
- lu_valid  input  1  long-latency result valid.
- lu_ready  output  1  arbiter can accept a long-latency result.
- lu_waddr  input  ADDR_WIDTH  long-latency destination register.
- lu_wdata  input  DATA_WIDTH  long-latency result.
- write_en  output  1  register file write enable (registered).
- write_addr  output  ADDR_WIDTH  register file write address (registered).
- write_data  output  DATA_WIDTH  register file write data (registered).
- query_addr  input  ADDR_WIDTH  source register being decoded.
- query_hit  output  1  query_addr matches a pending FIFO entry.
- pend_cnt  output  log2(FIFO_DEPTH)+1  FIFO occupancy.

Behaviour:
- Reset (rst=0, asynchronous): write_en=0, write_addr=0, write_data=0, FIFO empty, pend_cnt=0. lu_ready=0 while rst=0. Reset asserted mid-operation discards all queued entries.
- lu_ready = !full. Push occurs when lu_valid && lu_ready.
  - Pushes with lu_waddr=0 complete the handshake but are dropped: no push, no output.
  - When full, no push occurs even if a pop happens in the same cycle.
- Pipeline writes with pipe_waddr=0 are treated as idle, so pipe_wen is ignored.
- Each cycle, the output register is selected in this order:
  1. Pipeline request valid (pipe_wen && pipe_waddr!=0): output register loads the pipe write. Latency is 1 cycle.
  2. Otherwise, FIFO non-empty: pop the head and load it into the output register.
  3. Otherwise: write_en goes to 0; write_addr/write_data hold their previous values.
- A long-latency result takes at least 2 cycles from handshake to write_en: push, then pop into the output register. A new push is never popped in the same cycle.
- FIFO:
  - Circular buffer with read/write pointers carrying an extra wrap bit.
  - full = pointers equal except for the wrap bit.
  - Simultaneous push and pop when not full: occupancy unchanged.
- query_hit: combinational OR over all valid FIFO entries of (entry_addr == query_addr).
  - Always 0 for query_addr=0.
  - Excludes the output register, which the register file already forwards.
- Ordering:
  - Queued long-latency writes complete in FIFO order.
  - Pipeline writes may overtake queued entries. Decode must stall on query_hit to avoid WAW/RAW hazards.
  - The arbiter does not reorder or merge entries.

Optional Feature:
- Macro: REG_WRITE_ARB_BYPASS_EN.
- Defined: when the FIFO is empty, there is no valid pipeline request, and a long-latency handshake occurs, the result goes directly into the output register. It is not pushed, and the latency is 1 cycle. query_hit is unaffected, because the entry never enters the FIFO.
- Undefined: all long-latency results pass through the FIFO, with a minimum latency of 2 cycles.

Test Plan:
1. Reset held low for 3 cycles with lu_valid=1 → write_en=0, write_addr=0, write_data=0, lu_ready=0, pend_cnt=0. Release → lu_ready=1 on the next cycle.
2. Pipe write addr=5 data=0xDEADBEEF for 1 cycle → next cycle write_en=1, write_addr=5, write_data=0xDEADBEEF. The cycle after that, write_en=0.
3. Pipe write to addr 0 with data=0x1234 → write_en stays 0. LU push to addr 0 → handshake completes, pend_cnt stays 0.
4. pipe_wen held high (addresses 1..6) for 6 cycles while LU pushes 5 results to addresses 10..14:
   - lu_ready drops after 4 pushes (pend_cnt=4); the 5th is held until a slot frees.
   - Once the pipeline goes idle, addresses 10,11,12,13,14 are written in order on consecutive cycles.
5. Queue addr=7 while the pipeline is busy → query_addr=7 gives query_hit=1 until the pop cycle, then 0. query_addr=0 always gives 0.
6. With the FIFO empty and pipe idle, LU pushes addr=9 data=0xA5A5A5A5:
   - Without REG_WRITE_ARB_BYPASS_EN: write_en=1 two cycles after the handshake.
   - With it: write_en=1 one cycle after the handshake, and pend_cnt stays 0 throughout.
